eep_ctrl: RTL
=============

Name: eep_ctrl

Overview:
Sequencer between the digital core and the 4-entry, 14-bit EEPROM macro. It takes one read or write command at a time over a valid/ready interface. It generates the EEPROM bus cycles (eep_cs_n, eep_r_w_n, eep_addr, wrt_data) and holds chrg_pmp_en for the required ≥3 ms programming window around every write. It returns read data, or write completion, as a one-cycle response pulse.

Parameters:
PRE_CYCLES, 16, clocks chrg_pmp_en is high before the write bus cycle (0 allowed).
CP_CYCLES, 1500000, clocks chrg_pmp_en stays high after the write bus cycle. Must be ≥ 1400003; elaboration-time check fails otherwise.

Ports:
clk  in  1  system clock
por_n  in  1  asynchronous active-low power-on reset
cmd_vld  in  1  command valid
cmd_wr  in  1  1 = write, 0 = read
cmd_addr  in  2  EEPROM word address
cmd_wdata  in  14  write data
cmd_rdy  out  1  controller idle; command accepted on posedge with cmd_vld & cmd_rdy
rsp_vld  out  1  one-cycle completion pulse
rsp_wr  out  1  type of completed command
rsp_rdata  out  14  read data; valid with rsp_vld & ~rsp_wr
eep_addr  out  2  EEPROM address
eep_cs_n  out  1  EEPROM chip select, active low
eep_r_w_n  out  1  1 = read, 0 = write
wrt_data  out  14  EEPROM write data
eep_rd_data  in  14  EEPROM read data; latch is transparent while clk is low during a read cycle
chrg_pmp_en  out  1  charge-pump enable

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-low on por_n. All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values:
  - eep_cs_n=1, eep_r_w_n=1, chrg_pmp_en=0.
  - cmd_rdy=1, rsp_vld=0, rsp_wr=0.
  - rsp_rdata=0, eep_addr=0, wrt_data=0.
  - State=IDLE, counter=0.
- States: IDLE, RD, PRE, WR, HOLD.
- IDLE:
  - cmd_rdy=1.
  - On acceptance, cmd_addr goes to eep_addr, cmd_wdata goes to wrt_data, and cmd_wr goes to the rsp_wr staging register.
  - cmd_rdy drops from the acceptance edge E0.
- Read (IDLE→RD→IDLE):
  - From E0 to E1: eep_cs_n=0, eep_r_w_n=1.
  - At E1: rsp_rdata <= eep_rd_data, eep_cs_n=1, rsp_vld=1 for exactly one cycle, cmd_rdy=1.
  - Latency from acceptance to rsp_vld is 1 cycle. Back-to-back reads are possible every 2 cycles.
- Write:
  - From E0: chrg_pmp_en=1.
  - PRE lasts PRE_CYCLES cycles; when PRE_CYCLES=0, the FSM goes IDLE→WR directly.
  - WR lasts exactly one cycle with eep_cs_n=0, eep_r_w_n=0.
  - HOLD: eep_cs_n=1, eep_r_w_n=1, chrg_pmp_en=1 for CP_CYCLES cycles, counted by a down-counter loaded on WR exit.
  - At HOLD exit: chrg_pmp_en=0, rsp_vld=1 for one cycle, rsp_wr=1, rsp_rdata unchanged, cmd_rdy=1.
  - chrg_pmp_en high time is exactly PRE_CYCLES+1+CP_CYCLES cycles, with no glitch.
- Counter width is $clog2(CP_CYCLES+1). The counter never wraps: a zero count in HOLD terminates HOLD.
- cmd_vld while cmd_rdy=0 is ignored, not queued; the requester holds cmd_vld. cmd inputs are don't-care outside acceptance.
- wrt_data and eep_addr stay stable from acceptance until the next acceptance.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous), including chrg_pmp_en=0 mid-HOLD. The word being written is then undefined; this is acceptable. cmd_rdy=1 on the first edge after por_n release.
- No other EEPROM bus activity occurs while chrg_pmp_en=1.

Decomposition:
- Shared package eep_pkg:
  - EEP_DW=14, EEP_AW=2, CP_HOLD_MIN=1400003.
  - State enum eep_state_t {IDLE, RD, PRE, WR, HOLD}.
- Sub-module eep_cp_timer:
  - Loadable down-counter with load, load value, and done output.
  - Reused for both the PRE and HOLD windows.

Test Plan:
1. Reset: por_n low, then released → cmd_rdy=1, eep_cs_n=1, chrg_pmp_en=0, rsp_vld=0; no EEPROM activity for 100 clocks.
2. Read: read addr 2 with EEPROM word 2 preloaded to 14'h0ABC → eep_cs_n low exactly 1 cycle, rsp_vld one cycle after acceptance, rsp_rdata=14'h0ABC, rsp_wr=0.
3. Write then read-back (defaults): write 14'h1A5C to addr 1 → chrg_pmp_en high exactly 1500017 cycles, single eep_cs_n/eep_r_w_n low cycle at PRE_CYCLES after acceptance, no model error message. Then read addr 1 → rsp_rdata=14'h1A5C.
4. Busy rejection: cmd_vld pulsed for a read of addr 0 during HOLD → not accepted, no bus cycle. Held cmd_vld is accepted on the first edge after the write rsp_vld.
5. Reset mid-HOLD: por_n low 500000 cycles into HOLD → chrg_pmp_en=0 and cmd_rdy=1 asynchronously. After release, a read of an untouched address returns its original value.
6. PRE_CYCLES=0, CP_CYCLES=1400003: write 14'h3FFF to addr 3 → WR cycle directly on the cycle after acceptance, chrg_pmp_en high 1400004 cycles, model reports no error, read-back = 14'h3FFF.

Source files
------------

// File: rtl/eep_pkg.sv
// eep_pkg: shared constants and types for the EEPROM sequencer.
//   EEP_DW      - EEPROM word width
//   EEP_AW      - EEPROM address width
//   CP_HOLD_MIN - shortest legal charge-pump hold after a write bus cycle, in clocks
//   eep_state_t - sequencer states
package eep_pkg;

    localparam int unsigned EEP_DW      = 14;
    localparam int unsigned EEP_AW      = 2;
    localparam int unsigned CP_HOLD_MIN = 1400003;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        PRE,
        WR,
        HOLD
    } eep_state_t;

endpackage

// File: rtl/eep_cp_timer.sv
// eep_cp_timer: loadable down-counter shared by the PRE and HOLD windows.
// Ports:
//   i_clk      - system clock
//   i_por_n    - asynchronous active-low reset (count returns to 0)
//   i_load     - load i_load_val (takes priority over counting)
//   i_load_val - value to load
//   i_en       - count down by one while non-zero
//   o_done     - count is zero
module eep_cp_timer #(
    parameter int unsigned CW = 21
) (
    input  logic          i_clk,
    input  logic          i_por_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    output logic          o_done
);

    logic [CW-1:0] r_cnt;

    // Saturates at zero so an enabled idle counter can never wrap.
    always_ff @(posedge i_clk or negedge i_por_n) begin
        if (!i_por_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/eep_ctrl.sv
// eep_ctrl: one-command-at-a-time sequencer for the 4 x 14-bit EEPROM macro.
// Ports:
//   i_clk, i_por_n             - clock, asynchronous active-low power-on reset
//   i_cmd_vld/o_cmd_rdy        - command handshake, accepted on posedge with both high
//   i_cmd_wr, i_cmd_addr,
//   i_cmd_wdata                - command type (1 = write), word address, write data
//   o_rsp_vld, o_rsp_wr,
//   o_rsp_rdata                - one-cycle completion pulse, its type, read data
//   o_eep_addr, o_eep_cs_n,
//   o_eep_r_w_n, o_wrt_data    - EEPROM bus (cs_n active low, r_w_n 1 = read)
//   i_eep_rd_data              - EEPROM read data, sampled at the end of the read cycle
//   o_chrg_pmp_en              - charge-pump enable around every write
// All outputs are registered from the next state, so no input reaches an output
// combinationally.
module eep_ctrl
    import eep_pkg::*;
#(
    parameter int unsigned PRE_CYCLES    = 16,
    parameter int unsigned CP_CYCLES     = 1500000,
    // Floor on CP_CYCLES; the default is the programming-window safety minimum.
    parameter int unsigned CP_MIN_CYCLES = CP_HOLD_MIN
) (
    input  logic              i_clk,
    input  logic              i_por_n,
    input  logic              i_cmd_vld,
    input  logic              i_cmd_wr,
    input  logic [EEP_AW-1:0] i_cmd_addr,
    input  logic [EEP_DW-1:0] i_cmd_wdata,
    output logic              o_cmd_rdy,
    output logic              o_rsp_vld,
    output logic              o_rsp_wr,
    output logic [EEP_DW-1:0] o_rsp_rdata,
    output logic [EEP_AW-1:0] o_eep_addr,
    output logic              o_eep_cs_n,
    output logic              o_eep_r_w_n,
    output logic [EEP_DW-1:0] o_wrt_data,
    input  logic [EEP_DW-1:0] i_eep_rd_data,
    output logic              o_chrg_pmp_en
);

    if (CP_CYCLES < CP_MIN_CYCLES) begin : g_cp_too_short
        $error("eep_ctrl: CP_CYCLES=%0d is below the minimum %0d", CP_CYCLES, CP_MIN_CYCLES);
    end

    localparam int unsigned CNT_MAX = (CP_CYCLES > PRE_CYCLES) ? CP_CYCLES : PRE_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    // The timer reaches zero on the last cycle of a window, hence the minus one.
    localparam logic [CW-1:0] PRE_LOAD  = (PRE_CYCLES == 0) ? '0 : CW'(PRE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(CP_CYCLES - 1);

    eep_state_t        r_state;
    eep_state_t        w_state_d;
    logic              w_accept;
    logic              w_finish;
    logic              w_ld;
    logic [CW-1:0]     w_ld_val;
    logic              w_tmr_en;
    logic              w_tmr_done;

    logic              r_cmd_rdy;
    logic              r_rsp_vld;
    logic              r_rsp_wr;
    logic              r_wr_stg;
    logic [EEP_DW-1:0] r_rsp_rdata;
    logic [EEP_AW-1:0] r_eep_addr;
    logic [EEP_DW-1:0] r_wrt_data;
    logic              r_eep_cs_n;
    logic              r_eep_r_w_n;
    logic              r_chrg_pmp_en;

    assign w_tmr_en = (r_state == PRE) || (r_state == HOLD);

    eep_cp_timer #(
        .CW (CW)
    ) u_timer (
        .i_clk      (i_clk),
        .i_por_n    (i_por_n),
        .i_load     (w_ld),
        .i_load_val (w_ld_val),
        .i_en       (w_tmr_en),
        .o_done     (w_tmr_done)
    );

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        w_finish  = 1'b0;
        w_ld      = 1'b0;
        w_ld_val  = '0;
        unique case (r_state)
            IDLE: begin
                if (i_cmd_vld) begin
                    w_accept = 1'b1;
                    if (!i_cmd_wr) begin
                        w_state_d = RD;
                    end else if (PRE_CYCLES == 0) begin
                        w_state_d = WR;
                    end else begin
                        w_state_d = PRE;
                        w_ld      = 1'b1;
                        w_ld_val  = PRE_LOAD;
                    end
                end
            end
            RD: begin
                w_state_d = IDLE;
                w_finish  = 1'b1;
            end
            PRE: begin
                if (w_tmr_done) begin
                    w_state_d = WR;
                end
            end
            WR: begin
                w_state_d = HOLD;
                w_ld      = 1'b1;
                w_ld_val  = HOLD_LOAD;
            end
            HOLD: begin
                if (w_tmr_done) begin
                    w_state_d = IDLE;
                    w_finish  = 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_por_n) begin
        if (!i_por_n) begin
            r_state       <= IDLE;
            r_cmd_rdy     <= 1'b1;
            r_rsp_vld     <= 1'b0;
            r_rsp_wr      <= 1'b0;
            r_wr_stg      <= 1'b0;
            r_rsp_rdata   <= '0;
            r_eep_addr    <= '0;
            r_wrt_data    <= '0;
            r_eep_cs_n    <= 1'b1;
            r_eep_r_w_n   <= 1'b1;
            r_chrg_pmp_en <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_cmd_rdy     <= (w_state_d == IDLE);
            r_rsp_vld     <= w_finish;
            r_eep_cs_n    <= !((w_state_d == RD) || (w_state_d == WR));
            r_eep_r_w_n   <= (w_state_d != WR);
            // Covers PRE, WR and HOLD contiguously, so the pump never glitches.
            r_chrg_pmp_en <= (w_state_d inside {PRE, WR, HOLD});
            if (w_accept) begin
                r_eep_addr <= i_cmd_addr;
                r_wrt_data <= i_cmd_wdata;
                r_wr_stg   <= i_cmd_wr;
            end
            if (w_finish) begin
                r_rsp_wr <= r_wr_stg;
                if (!r_wr_stg) begin
                    r_rsp_rdata <= i_eep_rd_data;
                end
            end
        end
    end

    assign o_cmd_rdy     = r_cmd_rdy;
    assign o_rsp_vld     = r_rsp_vld;
    assign o_rsp_wr      = r_rsp_wr;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_eep_addr    = r_eep_addr;
    assign o_eep_cs_n    = r_eep_cs_n;
    assign o_eep_r_w_n   = r_eep_r_w_n;
    assign o_wrt_data    = r_wrt_data;
    assign o_chrg_pmp_en = r_chrg_pmp_en;

endmodule
